sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock synchronous FIFO with write acknowledge, overflow/underflow error
//  flags and full/almost-full/empty/almost-empty status. Sits between a producer and
//  a consumer in the same clock domain and connects through the FIFO interface bundle.
//  Registered read data; status flags are combinational from the occupancy counter.
// PARAMETERS
//  FIFO_WIDTH  16  data word width in bits
//  FIFO_DEPTH  8   number of entries; power of two, >= 4
// PORTS
//  clk          in   1           rising-edge clock, the only clock
//  rst          in   1           reset: synchronous, active-high
//  data_in      in   FIFO_WIDTH  write data
//  wr_en        in   1           write request
//  rd_en        in   1           read request
//  data_out     out  FIFO_WIDTH  read data, registered
//  wr_ack       out  1           registered: previous-cycle write accepted
//  overflow     out  1           registered: previous-cycle write rejected (full)
//  underflow    out  1           registered: previous-cycle read rejected (empty)
//  full         out  1           count == FIFO_DEPTH
//  almostfull   out  1           count == FIFO_DEPTH-1
//  empty        out  1           count == 0
//  almostempty  out  1           count == 1
// BEHAVIOUR
//  - State: mem[FIFO_DEPTH], wr_ptr/rd_ptr log2(DEPTH) bits, count log2(DEPTH)+1 bits.
//  - rst=1 at a clk edge: wr_ptr=rd_ptr=count=0, data_out=0, wr_ack=overflow=underflow=0;
//    mem contents undefined. Reset overrides wr_en/rd_en that cycle. After reset, empty=1,
//    full=almostfull=almostempty=0. Reset mid-operation discards all stored data.
//  - Write accepted when wr_en && !full: mem[wr_ptr]<=data_in, wr_ptr++ (wraps at DEPTH),
//    wr_ack<=1 for the next cycle. Else wr_ack<=0.
//  - overflow<=wr_en && full; underflow<=rd_en && empty; both cleared next edge otherwise.
//  - Read accepted when rd_en && !empty: data_out<=mem[rd_ptr], rd_ptr++ (wraps).
//    Read data valid the cycle after rd_en (latency 1). data_out holds otherwise.
//  - count: +1 on write only, -1 on read only, unchanged on both or neither.
//  - Simultaneous wr_en && rd_en: if empty, only write happens (underflow=1 next cycle);
//    if full, only read happens (overflow=1 next cycle); else both, count unchanged.
//  - Pointers wrap modulo FIFO_DEPTH; count never exceeds DEPTH nor goes below 0.
//  - Status flags combinational from count, valid same cycle as count update.
// CONFIGURATION
//  SYNC_FIFO_SVA_EN defined: embedded concurrent assertions compiled in, checking:
//   reset values; full<->count==DEPTH; empty<->count==0; almost flags; wr_ack after
//   accepted write; overflow/underflow after rejected access; pointer/count increment
//   rules; count<=DEPTH. Each assertion also has a cover property.
//  Not defined: no assertion code; RTL functional behaviour identical.
// TESTING
//  1 rst=1 one cycle -> empty=1, full=0, wr_ack=overflow=underflow=0, data_out=0.
//  2 Write 8 words 0x0001..0x0008 -> wr_ack=1 each next cycle; after 7th almostfull=1;
//    after 8th full=1. 9th write 0xFFFF -> overflow=1 next cycle, wr_ack=0, contents kept.
//  3 Read 8 times -> data_out 0x0001..0x0008 in order, one cycle after each rd_en;
//    almostempty=1 at count 1, empty=1 after last; 9th read -> underflow=1, data_out=0x0008.
//  4 Empty, wr_en=rd_en=1 with 0x00AA -> write only, count=1, underflow=1; next cycle
//    both again with 0x00BB -> data_out=0x00AA, count stays 1.
//  5 Full, wr_en=rd_en=1 -> read only, overflow=1, count=7, full=0.
//  6 Fill 5 words, assert rst mid-stream -> empty=1, count=0; a following write/read of
//    0x1234 returns 0x1234 (pointers wrapped correctly after 12+ total writes).

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock synchronous FIFO with registered read data, write acknowledge,
// overflow/underflow flags and occupancy status. Define SYNC_FIFO_SVA_EN to embed assertions.
module sync_fifo #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  almostfull,
  output logic                  empty,
  output logic                  almostempty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_AFULL = (AW+1)'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [FIFO_WIDTH-1:0] data_out_q;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  wr_accept, rd_accept;

  // Full blocks writes and empty blocks reads, so a simultaneous request at
  // either boundary degenerates to a single operation.
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_accept;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
      if (rd_accept) data_out_q <= mem_q[rd_ptr_q];
    end
  end

  // Storage has no reset so it maps onto block RAM; a reset only moves pointers.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out    = data_out_q;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign full        = (count_q == CNT_FULL);
  assign almostfull  = (count_q == CNT_AFULL);
  assign empty       = (count_q == '0);
  assign almostempty = (count_q == CNT_ONE);

`ifdef SYNC_FIFO_SVA_EN
  property p_reset_values;
    @(posedge clk) rst |=> (count_q == '0 && wr_ptr_q == '0 && rd_ptr_q == '0 &&
                            data_out_q == '0 && !wr_ack_q && !overflow_q && !underflow_q);
  endproperty
  a_reset_values: assert property (p_reset_values);
  c_reset_values: cover property (p_reset_values);

  property p_full_flag;
    @(posedge clk) full == (count_q == CNT_FULL);
  endproperty
  a_full_flag: assert property (p_full_flag);
  c_full_flag: cover property (@(posedge clk) full);

  property p_empty_flag;
    @(posedge clk) empty == (count_q == '0);
  endproperty
  a_empty_flag: assert property (p_empty_flag);
  c_empty_flag: cover property (@(posedge clk) empty);

  property p_almost_flags;
    @(posedge clk) (almostfull == (count_q == CNT_AFULL)) &&
                   (almostempty == (count_q == CNT_ONE));
  endproperty
  a_almost_flags: assert property (p_almost_flags);
  c_almost_flags: cover property (@(posedge clk) almostfull || almostempty);

  property p_wr_ack;
    @(posedge clk) disable iff (rst) (wr_en && !full) |=> wr_ack;
  endproperty
  a_wr_ack: assert property (p_wr_ack);
  c_wr_ack: cover property (p_wr_ack);

  property p_overflow;
    @(posedge clk) disable iff (rst) (wr_en && full) |=> (overflow && !wr_ack);
  endproperty
  a_overflow: assert property (p_overflow);
  c_overflow: cover property (p_overflow);

  property p_underflow;
    @(posedge clk) disable iff (rst) (rd_en && empty) |=> underflow;
  endproperty
  a_underflow: assert property (p_underflow);
  c_underflow: cover property (p_underflow);

  property p_wr_ptr_inc;
    @(posedge clk) disable iff (rst) (wr_en && !full) |=> wr_ptr_q == $past(wr_ptr_q) + PTR_ONE;
  endproperty
  a_wr_ptr_inc: assert property (p_wr_ptr_inc);
  c_wr_ptr_inc: cover property (p_wr_ptr_inc);

  property p_rd_ptr_inc;
    @(posedge clk) disable iff (rst) (rd_en && !empty) |=> rd_ptr_q == $past(rd_ptr_q) + PTR_ONE;
  endproperty
  a_rd_ptr_inc: assert property (p_rd_ptr_inc);
  c_rd_ptr_inc: cover property (p_rd_ptr_inc);

  property p_count_up;
    @(posedge clk) disable iff (rst) (wr_accept && !rd_accept) |=> count_q == $past(count_q) + CNT_ONE;
  endproperty
  a_count_up: assert property (p_count_up);
  c_count_up: cover property (p_count_up);

  property p_count_down;
    @(posedge clk) disable iff (rst) (rd_accept && !wr_accept) |=> count_q == $past(count_q) - CNT_ONE;
  endproperty
  a_count_down: assert property (p_count_down);
  c_count_down: cover property (p_count_down);

  property p_count_hold;
    @(posedge clk) disable iff (rst) (wr_accept == rd_accept) |=> $stable(count_q);
  endproperty
  a_count_hold: assert property (p_count_hold);
  c_count_hold: cover property (p_count_hold);

  property p_count_bound;
    @(posedge clk) count_q <= CNT_FULL;
  endproperty
  a_count_bound: assert property (p_count_bound);
  c_count_bound: cover property (@(posedge clk) count_q == CNT_FULL);
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: reset, fill/overflow, drain/underflow,
// simultaneous access at empty and full, and reset in the middle of traffic.
module tb_sync_fifo;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_out;
  logic        wr_ack;
  logic        overflow;
  logic        underflow;
  logic        full;
  logic        almostfull;
  logic        empty;
  logic        almostempty;

  int n_checks = 0;
  int n_fail   = 0;

  sync_fifo #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .almostfull  (almostfull),
    .empty       (empty),
    .almostempty (almostempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h7777;
    step();
    step();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    $display("reset: empty=%b full=%b data_out=%h", empty, full, data_out);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (almostfull !== 1'b0 || almostempty !== 1'b0) begin n_fail++; $display("FAIL reset_almost: got af=%b ae=%b expected 0 0", almostfull, almostempty); end
    n_checks++; if ({wr_ack, overflow, underflow} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {wr_ack, overflow, underflow}); end
    n_checks++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h expected 0000", data_out); end
  endtask

  task automatic test_fill_overflow();
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 16'(i + 1);
      step();
      $display("write %h: wr_ack=%b af=%b full=%b", data_in, wr_ack, almostfull, full);
      n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL fill_ack[%0d]: got %b expected 1", i, wr_ack); end
      if (i == 6) begin
        n_checks++; if (almostfull !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL fill_almostfull: got af=%b full=%b expected 1 0", almostfull, full); end
      end
      if (i == 7) begin
        n_checks++; if (full !== 1'b1 || almostfull !== 1'b0) begin n_fail++; $display("FAIL fill_full: got full=%b af=%b expected 1 0", full, almostfull); end
      end
    end
    data_in = 16'hFFFF;
    step();
    $display("write ffff when full: overflow=%b wr_ack=%b", overflow, wr_ack);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", overflow); end
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL overflow_ack: got %b expected 0", wr_ack); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL overflow_full: got %b expected 1", full); end
    wr_en = 1'b0;
    step();
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_drain_underflow();
    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      $display("read: data_out=%h ae=%b empty=%b", data_out, almostempty, empty);
      n_checks++; if (data_out !== 16'(i + 1)) begin n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 16'(i + 1)); end
      if (i == 6) begin
        n_checks++; if (almostempty !== 1'b1) begin n_fail++; $display("FAIL drain_almostempty: got %b expected 1", almostempty); end
      end
      if (i == 7) begin
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b expected 1", empty); end
      end
    end
    step();
    $display("read when empty: underflow=%b data_out=%h", underflow, data_out);
    n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL underflow_set: got %b expected 1", underflow); end
    n_checks++; if (data_out !== 16'h0008) begin n_fail++; $display("FAIL underflow_data: got %h expected 0008", data_out); end
    rd_en = 1'b0;
    step();
    n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL underflow_clear: got %b expected 0", underflow); end
  endtask

  task automatic test_simul_empty();
    wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h00AA;
    step();
    $display("rw at empty 00aa: underflow=%b wr_ack=%b ae=%b data_out=%h", underflow, wr_ack, almostempty, data_out);
    n_checks++; if (underflow !== 1'b1 || wr_ack !== 1'b1) begin n_fail++; $display("FAIL simul_empty_flags: got uf=%b ack=%b expected 1 1", underflow, wr_ack); end
    n_checks++; if (almostempty !== 1'b1) begin n_fail++; $display("FAIL simul_empty_count: got ae=%b expected 1", almostempty); end
    n_checks++; if (data_out !== 16'h0008) begin n_fail++; $display("FAIL simul_empty_hold: got %h expected 0008", data_out); end
    data_in = 16'h00BB;
    step();
    $display("rw at count1 00bb: data_out=%h ae=%b", data_out, almostempty);
    n_checks++; if (data_out !== 16'h00AA) begin n_fail++; $display("FAIL simul_both_data: got %h expected 00aa", data_out); end
    n_checks++; if (almostempty !== 1'b1 || underflow !== 1'b0) begin n_fail++; $display("FAIL simul_both_count: got ae=%b uf=%b expected 1 0", almostempty, underflow); end
    wr_en = 1'b0;
    step();
    rd_en = 1'b0;
    n_checks++; if (data_out !== 16'h00BB || empty !== 1'b1) begin n_fail++; $display("FAIL simul_tail: got %h empty=%b expected 00bb 1", data_out, empty); end
  endtask

  task automatic test_simul_full();
    wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = 16'h0010 + 16'(i);
      step();
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_full_pre: got %b expected 1", full); end
    rd_en = 1'b1; data_in = 16'h5555;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    $display("rw at full 5555: overflow=%b wr_ack=%b full=%b af=%b data_out=%h", overflow, wr_ack, full, almostfull, data_out);
    n_checks++; if (overflow !== 1'b1 || wr_ack !== 1'b0) begin n_fail++; $display("FAIL simul_full_flags: got ov=%b ack=%b expected 1 0", overflow, wr_ack); end
    n_checks++; if (full !== 1'b0 || almostfull !== 1'b1) begin n_fail++; $display("FAIL simul_full_count: got full=%b af=%b expected 0 1", full, almostfull); end
    n_checks++; if (data_out !== 16'h0010) begin n_fail++; $display("FAIL simul_full_data: got %h expected 0010", data_out); end
    rd_en = 1'b1;
    for (int i = 1; i < 8; i++) begin
      step();
      n_checks++; if (data_out !== 16'h0010 + 16'(i)) begin n_fail++; $display("FAIL simul_full_drain[%0d]: got %h expected %h", i, data_out, 16'h0010 + 16'(i)); end
    end
    rd_en = 1'b0;
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_full_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_midstream();
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_in = 16'h0020 + 16'(i);
      step();
    end
    rst = 1'b1; data_in = 16'h0099;
    step();
    rst = 1'b0; wr_en = 1'b0;
    $display("mid reset: empty=%b ae=%b data_out=%h", empty, almostempty, data_out);
    n_checks++; if (empty !== 1'b1 || almostempty !== 1'b0) begin n_fail++; $display("FAIL midreset_empty: got empty=%b ae=%b expected 1 0", empty, almostempty); end
    n_checks++; if (data_out !== 16'h0000 || wr_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_regs: got %h ack=%b expected 0000 0", data_out, wr_ack); end
    wr_en = 1'b1; data_in = 16'h1234;
    step();
    wr_en = 1'b0;
    n_checks++; if (almostempty !== 1'b1 || wr_ack !== 1'b1) begin n_fail++; $display("FAIL postreset_write: got ae=%b ack=%b expected 1 1", almostempty, wr_ack); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    $display("post reset read: data_out=%h empty=%b", data_out, empty);
    n_checks++; if (data_out !== 16'h1234 || empty !== 1'b1) begin n_fail++; $display("FAIL postreset_read: got %h empty=%b expected 1234 1", data_out, empty); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simul_empty();
    test_simul_full();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
